// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN pooling front end.
package cnn_pkg;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_POOL_KERNEL = 2;

  typedef logic [DEF_POOL_KERNEL-1:0][DEF_POOL_KERNEL-1:0][DEF_DATA_WIDTH-1:0] pixel_win_t;

  typedef enum logic {FILL_TOP, PAIR_BOTTOM} pool_state_e;
endpackage

// File: rtl/maxpool_window_buffer_line_buffer_ram.sv
// One-row line buffer: single write port, two combinational read ports.
module line_buffer_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
)(
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr0,
  input  logic [AW-1:0]         rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];
endmodule

// File: rtl/maxpool_window_buffer.sv
// Streaming 2x2 stride-2 window former feeding the max-pool stage.
module maxpool_window_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_POOL_KERNEL = DEF_POOL_KERNEL,
  parameter int IMG_WIDTH       = 32,
  parameter int IMG_HEIGHT      = 32
)(
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [DATA_WIDTH-1:0]                                      pixel_in,
  input  logic                                                       pixel_valid,
  output logic [MAX_POOL_KERNEL-1:0][MAX_POOL_KERNEL-1:0][DATA_WIDTH-1:0] window_out,
  output logic                                                       window_valid,
  output logic                                                       frame_done,
  output logic [$clog2(IMG_HEIGHT)-1:0]                              row_idx
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  generate
    if (MAX_POOL_KERNEL != 2) begin : g_bad_kernel
      $error("maxpool_window_buffer supports only MAX_POOL_KERNEL == 2");
    end
    if (IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_bad_dims
      $error("maxpool_window_buffer needs IMG_WIDTH and IMG_HEIGHT >= 2");
    end
  endgenerate

  pool_state_e           state_q, state_d;
  logic [CW-1:0]         col, col_even;
  logic [DATA_WIDTH-1:0] prev_pix, lb_rd0, lb_rd1;
  logic                  last_col, last_row, lb_we, win_fire;

  assign last_col = (col == COL_LAST);
  assign last_row = (row_idx == ROW_LAST);

  always_comb begin
    state_d  = state_q;
    lb_we    = 1'b0;
    win_fire = 1'b0;
    col_even = col;
    col_even[0] = 1'b0;
    if (pixel_valid) begin
      case (state_q)
        FILL_TOP: begin
          lb_we = 1'b1;
          // an odd-height frame ends in FILL_TOP; the orphan row is never paired
          if (last_col && !last_row) state_d = PAIR_BOTTOM;
        end
        PAIR_BOTTOM: begin
          win_fire = col[0];
          if (last_col) state_d = FILL_TOP;
        end
        default: state_d = FILL_TOP;
      endcase
    end
  end

  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .AW         (CW)
  ) u_linebuf (
    .clk      (clk),
    .we       (lb_we),
    .wr_addr  (col),
    .wr_data  (pixel_in),
    .rd_addr0 (col_even),
    .rd_addr1 (col),
    .rd_data0 (lb_rd0),
    .rd_data1 (lb_rd1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL_TOP;
      col          <= '0;
      row_idx      <= '0;
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_valid <= win_fire;
      frame_done   <= pixel_valid && last_col && last_row;
      if (pixel_valid) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row_idx <= last_row ? '0 : row_idx + RW'(1);
      end
      if (win_fire) begin
        window_out[0][0] <= lb_rd0;
        window_out[0][1] <= lb_rd1;
        window_out[1][0] <= prev_pix;
        window_out[1][1] <= pixel_in;
      end
    end
  end

  // bottom-left pixel is held until its right neighbour arrives
  always_ff @(posedge clk) begin
    if (pixel_valid && state_q == PAIR_BOTTOM && !col[0]) prev_pix <= pixel_in;
  end
endmodule

// File: tb/tb_maxpool_window_buffer.sv
// Scoreboard bench: 4x4 and 5x5 instances against a frame-image reference model.
module tb_maxpool_window_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]           pix [2];
  logic                  pv  [2];
  logic [1:0][1:0][15:0] win [2];
  logic                  wv  [2];
  logic                  fd  [2];
  logic [1:0]            row0;
  logic [2:0]            row1;

  maxpool_window_buffer #(.DATA_WIDTH(16), .MAX_POOL_KERNEL(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .pixel_in(pix[0]), .pixel_valid(pv[0]),
    .window_out(win[0]), .window_valid(wv[0]), .frame_done(fd[0]), .row_idx(row0));

  maxpool_window_buffer #(.DATA_WIDTH(16), .MAX_POOL_KERNEL(2), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk(clk), .rst(rst), .pixel_in(pix[1]), .pixel_valid(pv[1]),
    .window_out(win[1]), .window_valid(wv[1]), .frame_done(fd[1]), .row_idx(row1));

  typedef struct {
    logic [63:0] w;
    int          cyc;
  } exp_t;

  exp_t wq0[$], wq1[$];
  int   fq0[$], fq1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   wd[2] = '{4, 5};
  int   hd[2] = '{4, 5};
  int   n[2]  = '{0, 0};
  logic [15:0] img [2][5][5];
  logic [63:0] last_w [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: place the pixel in a frame image by its raster index; every
  // odd-row/odd-col pixel completes the 2x2 block above-left of it.
  task automatic model_accept(int d, logic [15:0] v);
    int r, c;
    exp_t e;
    r = n[d] / wd[d];
    c = n[d] % wd[d];
    img[d][r][c] = v;
    if (r % 2 == 1 && c % 2 == 1) begin
      e.w   = {v, img[d][r][c-1], img[d][r-1][c], img[d][r-1][c-1]};
      e.cyc = cyc + 1;
      if (d == 0) wq0.push_back(e); else wq1.push_back(e);
    end
    if (n[d] == wd[d] * hd[d] - 1) begin
      if (d == 0) fq0.push_back(cyc + 1); else fq1.push_back(cyc + 1);
      n[d] = 0;
    end else begin
      n[d]++;
    end
  endtask

  task automatic drive(int d, logic [15:0] v, bit vld);
    @(posedge clk); #1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    pix[d] = v;
    pv[d]  = vld;
    if (vld) model_accept(d, v);
  endtask

  task automatic idle(int k);
    repeat (k) drive(0, 16'h0, 1'b0);
  endtask

  task automatic send_frame(int d, int base, int gap, bit rnd);
    int i, t;
    bit g;
    i = 0;
    t = 0;
    while (i < wd[d] * hd[d]) begin
      g = (gap == 1) ? t[0] : ((gap == 2) ? ($urandom_range(0, 2) == 0) : 1'b0);
      if (g) drive(d, 16'hDEAD, 1'b0);
      else begin
        drive(d, rnd ? 16'($urandom) : 16'(base + i), 1'b1);
        i++;
      end
      t++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    n[0] = 0;
    n[1] = 0;
    wq0.delete(); wq1.delete(); fq0.delete(); fq1.delete();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_window_out%0d", d), win[d], 64'h0);
      chk($sformatf("rst_window_valid%0d", d), 64'(wv[d]), 64'h0);
      chk($sformatf("rst_frame_done%0d", d), 64'(fd[d]), 64'h0);
    end
    chk("rst_row_idx0", 64'(row0), 64'h0);
    chk("rst_row_idx1", 64'(row1), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic mon(int d);
    exp_t e;
    int   f;
    bit   empty;
    if (wv[d]) begin
      empty = (d == 0) ? (wq0.size() == 0) : (wq1.size() == 0);
      if (empty) chk($sformatf("win%0d_unexpected_valid", d), 64'h1, 64'h0);
      else begin
        if (d == 0) e = wq0.pop_front(); else e = wq1.pop_front();
        chk($sformatf("win%0d_data", d), win[d], e.w);
        chk($sformatf("win%0d_cycle", d), 64'(cyc), 64'(e.cyc));
      end
      last_w[d] = win[d];
    end else begin
      chk($sformatf("win%0d_hold", d), win[d], last_w[d]);
    end
    if (fd[d]) begin
      empty = (d == 0) ? (fq0.size() == 0) : (fq1.size() == 0);
      if (empty) chk($sformatf("fd%0d_unexpected", d), 64'h1, 64'h0);
      else begin
        if (d == 0) f = fq0.pop_front(); else f = fq1.pop_front();
        chk($sformatf("fd%0d_cycle", d), 64'(cyc), 64'(f));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_w[0] = '0;
      last_w[1] = '0;
    end else begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  initial begin
    pix[0] = '0; pix[1] = '0;
    pv[0]  = 1'b0; pv[1] = 1'b0;
    do_reset();

    send_frame(0, 0, 0, 1'b0);
    idle(3);
    @(negedge clk);
    chk("row_idx0_after_frame", 64'(row0), 64'h0);

    send_frame(0, 0, 1, 1'b0);
    idle(3);

    send_frame(0, 0, 0, 1'b0);
    send_frame(0, 100, 0, 1'b0);
    idle(3);

    for (int i = 0; i <= 6; i++) drive(0, 16'(i), 1'b1);
    idle(1);
    @(negedge clk);
    chk("row_idx0_mid_frame", 64'(row0), 64'h1);
    do_reset();
    send_frame(0, 0, 0, 1'b0);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      case (i)
        0: v = 16'h8000;
        1: v = 16'hFFFF;
        4: v = 16'h0001;
        5: v = 16'h7FFF;
        default: v = 16'($urandom);
      endcase
      drive(0, v, 1'b1);
      if (i == 5) begin
        idle(1);
        @(negedge clk);
        chk("signed_window_exact", win[0], 64'h7FFF_0001_FFFF_8000);
      end
    end
    idle(3);

    send_frame(1, 0, 0, 1'b0);
    idle(3);
    @(negedge clk);
    chk("row_idx1_after_frame", 64'(row1), 64'h0);

    repeat (3) send_frame(1, 0, 2, 1'b1);
    repeat (3) send_frame(0, 0, 2, 1'b1);
    idle(5);

    chk("win0_queue_drained", 64'(wq0.size()), 64'h0);
    chk("win1_queue_drained", 64'(wq1.size()), 64'h0);
    chk("fd0_queue_drained", 64'(fq0.size()), 64'h0);
    chk("fd1_queue_drained", 64'(fq1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
